// File: rtl/discrete_i2s_tx.sv
// Discrete-sound sink: double-buffers signed 16-bit L/R samples and serialises them as I2S (MSB first, one-bit delay).
// Latency: a sample captured before a frame load appears on sdata at the load cycle; no backpressure, underrun/overrun are flagged instead.
module discrete_i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        I_RSTn,
  input  logic        audio_clk_en,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  input  logic        mute,
  output logic        sclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic        overrun
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] staging;
  logic [31:0] last_frame;
  logic [31:0] shreg;
  logic        fresh;

  logic        wrap;
  logic        sclk_fall;
  logic        load;
  logic [4:0]  slot_next;
  logic [31:0] load_word;

  always_comb begin
    wrap      = (div_cnt == DIV_LAST);
    sclk_fall = wrap & sclk;
    slot_next = bit_cnt + 5'd1;
    load      = sclk_fall & (slot_next == 5'd1);
    // The load always consumes the pre-capture staging value, even if a strobe lands on the same cycle.
    load_word = mute ? 32'd0 : (fresh ? staging : last_frame);
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      div_cnt    <= 8'd0;
      bit_cnt    <= 5'd31;
      sclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
      staging    <= 32'd0;
      last_frame <= 32'd0;
      shreg      <= 32'd0;
      fresh      <= 1'b0;
    end else begin
      div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
      if (wrap) sclk <= ~sclk;

      if (sclk_fall) begin
        bit_cnt <= slot_next;
        lrclk   <= slot_next[4];
        if (load) begin
          sdata <= load_word[31];
          shreg <= {load_word[30:0], 1'b0};
        end else begin
          sdata <= shreg[31];
          shreg <= {shreg[30:0], 1'b0};
        end
      end

      underrun <= load & ~fresh;
      overrun  <= audio_clk_en & fresh & ~load;

      if (load && fresh) last_frame <= staging;

      if (audio_clk_en) begin
        staging <= {in_left, in_right};
        fresh   <= 1'b1;
      end else if (load) begin
        fresh <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_discrete_i2s_tx.sv
// Bench for discrete_i2s_tx: directed frame scenarios plus random strobes/mute against a slot-level reference model.
module tb_discrete_i2s_tx;
  localparam int D = 2;

  logic        clk;
  logic        I_RSTn;
  logic        audio_clk_en;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        mute;
  logic        sclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;
  logic        overrun;

  discrete_i2s_tx #(.BCLK_DIV(D)) dut (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .in_left      (in_left),
    .in_right     (in_right),
    .mute         (mute),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycle number since reset release decides sclk and slot index directly.
  int          cyc;
  int          k_m;
  logic [31:0] stag_m, last_m, cur_m;
  logic        fresh_m;
  logic        fall_m, load_m;
  logic        e_sclk, e_lr, e_sd, e_und, e_ovr;
  logic        obs [32];
  logic [31:0] rx_word;

  task automatic model_reset();
    cyc = 0; k_m = 0;
    stag_m = 0; last_m = 0; cur_m = 0; fresh_m = 0;
    fall_m = 0; load_m = 0;
    e_sclk = 0; e_lr = 0; e_sd = 0; e_und = 0; e_ovr = 0;
    rx_word = 0;
    for (int i = 0; i < 32; i++) obs[i] = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic [31:0] data, input logic mu);
    logic old_fresh;
    old_fresh = fresh_m;
    cyc++;
    fall_m = (cyc % (2 * D) == 0);
    load_m = 1'b0;
    if (fall_m) begin
      k_m    = (cyc / (2 * D) - 1) % 32;
      load_m = (k_m == 1);
    end
    e_und = 1'b0;
    e_ovr = 1'b0;
    if (load_m) begin
      e_und = !old_fresh;
      cur_m = mu ? 32'd0 : (old_fresh ? stag_m : last_m);
      if (old_fresh) last_m = stag_m;
      fresh_m = 1'b0;
    end
    if (en) begin
      e_ovr   = old_fresh && !load_m;
      stag_m  = data;
      fresh_m = 1'b1;
    end
    e_sclk = ((cyc / D) % 2) == 1;
    e_lr   = (k_m >= 16);
    e_sd   = cur_m[(32 - k_m) % 32];
  endtask

  task automatic step(input logic en, input logic [15:0] lv, input logic [15:0] rv, input logic mu);
    audio_clk_en = en;
    in_left      = lv;
    in_right     = rv;
    mute         = mu;
    @(posedge clk);
    model_edge(en, {lv, rv}, mu);
    #1;
    chk("outs", {27'd0, sclk, lrclk, sdata, underrun, overrun},
        {27'd0, e_sclk, e_lr, e_sd, e_und, e_ovr});
    // Reassemble the frame that just finished from the observed serial bits.
    if (fall_m) begin
      if (k_m == 1) begin
        for (int i = 1; i < 32; i++) rx_word[32 - i] = obs[i];
        rx_word[0] = obs[0];
      end
      obs[k_m] = sdata;
    end
  endtask

  task automatic idle_to(input int n, input logic mu);
    while (cyc < n) step(1'b0, 16'h0, 16'h0, mu);
  endtask

  logic [15:0] rl, rr;

  initial begin
    I_RSTn = 1'b0;
    audio_clk_en = 1'b0;
    in_left = 16'h0;
    in_right = 16'h0;
    mute = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {27'd0, sclk, lrclk, sdata, underrun, overrun}, 32'd0);
    @(negedge clk);
    I_RSTn = 1'b1;

    // Bit clock phase and period
    step(1'b0, 16'h0, 16'h0, 1'b0);
    chk("sclk_c1", {31'd0, sclk}, 32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    chk("sclk_rise", {31'd0, sclk}, 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    chk("sclk_fall", {29'd0, sclk, lrclk, sdata}, 32'd0);
    idle_to(6, 1'b0);
    chk("sclk_period", {31'd0, sclk}, 32'd1);

    // Basic frame, then underrun repeat
    step(1'b1, 16'h8001, 16'h7FFE, 1'b0);
    idle_to(8, 1'b0);
    chk("basic_no_underrun", {31'd0, underrun}, 32'd0);
    chk("basic_first_bit", {31'd0, sdata}, 32'd1);
    idle_to(136, 1'b0);
    chk("basic_frame", rx_word, 32'h8001_7FFE);
    chk("underrun_pulse", {31'd0, underrun}, 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    chk("underrun_single", {31'd0, underrun}, 32'd0);

    // Overrun within one frame
    idle_to(149, 1'b0);
    step(1'b1, 16'h1234, 16'h5678, 1'b0);
    chk("ovr_first", {31'd0, overrun}, 32'd0);
    idle_to(169, 1'b0);
    step(1'b1, 16'hABCD, 16'h0F0F, 1'b0);
    chk("ovr_second", {31'd0, overrun}, 32'd1);
    idle_to(264, 1'b0);
    chk("underrun_repeat", rx_word, 32'h8001_7FFE);
    chk("ovr_load_fresh", {31'd0, underrun}, 32'd0);

    // Strobe exactly on the load cycle with nothing fresh
    idle_to(391, 1'b0);
    step(1'b1, 16'h1111, 16'h2222, 1'b0);
    chk("simul_underrun", {31'd0, underrun}, 32'd1);
    chk("simul_overrun", {31'd0, overrun}, 32'd0);
    chk("ovr_frame", rx_word, 32'hABCD_0F0F);
    idle_to(520, 1'b0);
    chk("simul_repeat", rx_word, 32'hABCD_0F0F);
    chk("simul_no_underrun", {31'd0, underrun}, 32'd0);

    // Mute across a load; L[7] forced high so slot 9 of the repeat frame drives a 1
    rl = 16'($urandom) | 16'h0080;
    rr = 16'($urandom);
    idle_to(599, 1'b0);
    step(1'b1, rl, rr, 1'b0);
    idle_to(645, 1'b0);
    idle_to(648, 1'b1);
    chk("simul_next", rx_word, 32'h1111_2222);
    idle_to(650, 1'b1);
    idle_to(776, 1'b0);
    chk("mute_frame", rx_word, 32'd0);

    // Reset in the middle of slot 9 while sclk is high
    for (int i = 0; i < 300 && k_m != 9; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    #2;
    I_RSTn = 1'b0;
    #1;
    chk("rst_async", {27'd0, sclk, lrclk, sdata, underrun, overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {27'd0, sclk, lrclk, sdata, underrun, overrun}, 32'd0);
    @(negedge clk);
    model_reset();
    I_RSTn = 1'b1;
    idle_to(8, 1'b0);
    chk("rst_underrun", {31'd0, underrun}, 32'd1);
    idle_to(136, 1'b0);
    chk("rst_zero_frame", rx_word, 32'd0);

    // Random strobes and mute against the model
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 99) == 0), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
